// File: rtl/adc_sar_seq_ovs.sv
// SAR ADC sequencer with oversampling/averaging, channel sequencing and a result FIFO.
// All converter state advances on the divided tick; the FIFO and the soc edge detector run every clk.
//
// state    | meaning
// S_IDLE   | no conversion running, waiting for a latched soc
// S_RST    | DAC held in reset for one tick
// S_SAMPLE | sample switch closed for swidth+1 ticks
// S_CONV   | successive approximation, one bit per tick, MSB first
// S_DONE   | conversion complete, accumulate and pick the next conversion
module adc_sar_seq_ovs #(
   parameter int RES      = 10,
   parameter int NCH      = 8,
   parameter int SEQ_LEN  = 8,
   parameter int FIFO_AW  = 4,
   parameter int CLKDIV_W = 8,
   parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [CLKDIV_W-1:0]        clkdiv,
   input  logic [3:0]                 swidth,
   input  logic                       cmp,
   input  logic                       soc,
   input  logic [1:0]                 mode,
   input  logic [CHW-1:0]             ch_sel,
   input  logic [SEQ_LEN*(CHW+1)-1:0] seq_cfg,
   input  logic [2:0]                 osr,
   input  logic                       abort,
   output logic [CHW-1:0]             ch_sel_out,
   output logic                       sample_n,
   output logic                       dac_rst,
   output logic                       busy,
   output logic                       eoc,
   output logic [RES-1:0]             result,
   input  logic                       rd,
   output logic [CHW+RES-1:0]         rdata,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic [FIFO_AW:0]           fifo_level,
   input  logic [FIFO_AW:0]           fifo_thr,
   output logic                       fifo_above,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   localparam int PW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int BW    = (RES > 1) ? $clog2(RES) : 1;
   localparam int AW    = RES + 7;
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {S_IDLE, S_RST, S_SAMPLE, S_CONV, S_DONE} state_t;

   state_t               r_state;
   logic [CLKDIV_W-1:0]  r_div;
   logic [3:0]           r_scnt;
   logic [BW-1:0]        r_bit;
   logic [RES-1:0]       r_sar;
   logic [AW-1:0]        r_acc;
   logic [7:0]           r_ncv;
   logic [PW-1:0]        r_step;
   logic                 r_seq;
   logic                 r_cont;
   logic                 r_end;
   logic [2:0]           r_osr;
   logic [CHW-1:0]       r_ch;
   logic                 r_soc_d;
   logic                 r_soc_lat;
   logic                 r_fin;
   logic [RES-1:0]       r_fin_data;
   logic [CHW-1:0]       r_fin_ch;
   logic                 r_eoc;
   logic [RES-1:0]       r_result;

   logic [CHW+RES-1:0]   r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wp;
   logic [FIFO_AW-1:0]   r_rp;
   logic [FIFO_AW:0]     r_level;
   logic                 r_ovf;

   logic                 w_tick;
   logic                 w_soc_rise;
   logic [PW-1:0]        w_next_ptr;
   logic [PW-1:0]        w_sptr;
   logic [CHW:0]         w_cfg;
   logic                 w_seq_nxt;
   logic [CHW-1:0]       w_ch_nxt;
   logic                 w_end_nxt;
   logic [AW-1:0]        w_sum;
   logic [7:0]           w_ncv_max;
   logic                 w_last_cv;
   logic                 w_start;
   logic                 w_fin_ok;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;

   assign w_tick = en && (r_div >= clkdiv);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
      end else if (en) begin
         r_div <= (r_div >= clkdiv) ? '0 : r_div + 1'b1;
      end
   end

   // Step selection: from IDLE a job always begins at step 0.
   assign w_next_ptr = r_end ? '0 : r_step + 1'b1;
   assign w_sptr     = (r_state == S_IDLE) ? '0 : w_next_ptr;
   assign w_cfg      = seq_cfg[int'(w_sptr) * (CHW+1) +: (CHW+1)];
   assign w_seq_nxt  = (mode == 2'b01) || (mode == 2'b10);
   assign w_ch_nxt   = w_seq_nxt ? w_cfg[CHW-1:0] : ch_sel;
   assign w_end_nxt  = w_cfg[CHW] || (w_sptr == PW'(SEQ_LEN-1));
   assign w_sum      = r_acc + AW'(r_sar);
   assign w_ncv_max  = (8'd1 << r_osr) - 8'd1;
   assign w_last_cv  = (r_ncv == w_ncv_max);
   assign w_start    = ((r_state == S_IDLE) && r_soc_lat) ||
                       ((r_state == S_DONE) && w_last_cv && r_seq && (!r_end || r_cont));
   assign w_soc_rise = soc && !r_soc_d;
   assign w_fin_ok   = r_fin && !abort && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_scnt     <= '0;
         r_bit      <= '0;
         r_sar      <= '0;
         r_acc      <= '0;
         r_ncv      <= '0;
         r_step     <= '0;
         r_seq      <= 1'b0;
         r_cont     <= 1'b0;
         r_end      <= 1'b0;
         r_osr      <= '0;
         r_ch       <= '0;
         r_soc_d    <= 1'b0;
         r_soc_lat  <= 1'b0;
         r_fin      <= 1'b0;
         r_fin_data <= '0;
         r_fin_ch   <= '0;
         r_eoc      <= 1'b0;
         r_result   <= '0;
      end else begin
         r_soc_d <= soc;
         r_fin   <= 1'b0;
         r_eoc   <= w_fin_ok;
         if (w_fin_ok) r_result <= r_fin_data;

         if (w_soc_rise && !busy) r_soc_lat <= 1'b1;
         else if (w_tick)         r_soc_lat <= 1'b0;

         if (abort) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_ncv     <= '0;
            r_step    <= '0;
            r_soc_lat <= 1'b0;
         end else if (w_tick) begin
            case (r_state)
               S_IDLE: r_state <= S_IDLE;
               S_RST: begin
                  r_state <= S_SAMPLE;
                  r_scnt  <= '0;
               end
               S_SAMPLE: begin
                  if (r_scnt == swidth) begin
                     r_state <= S_CONV;
                     r_sar   <= {1'b1, {(RES-1){1'b0}}};
                     r_bit   <= BW'(RES-1);
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
               // Resolve the bit under trial and raise the next lower one.
               S_CONV: begin
                  r_sar[r_bit] <= cmp;
                  if (r_bit != '0) begin
                     r_sar[r_bit - 1'b1] <= 1'b1;
                     r_bit               <= r_bit - 1'b1;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
               S_DONE: begin
                  if (!w_last_cv) begin
                     r_acc   <= w_sum;
                     r_ncv   <= r_ncv + 1'b1;
                     r_state <= S_RST;
                  end else begin
                     r_fin      <= 1'b1;
                     r_fin_data <= RES'(w_sum >> r_osr);
                     r_fin_ch   <= r_ch;
                     r_acc      <= '0;
                     r_ncv      <= '0;
                     r_step     <= '0;
                     r_state    <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
            // Step start overrides the DONE/IDLE outcome above.
            if (w_start) begin
               r_state <= S_RST;
               r_seq   <= w_seq_nxt;
               r_cont  <= (mode == 2'b10);
               r_osr   <= osr;
               r_ch    <= w_ch_nxt;
               r_end   <= w_end_nxt;
               r_step  <= w_sptr;
               r_acc   <= '0;
               r_ncv   <= '0;
            end
         end
      end
   end

   assign w_full  = (r_level == (FIFO_AW+1)'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = rd && !w_empty;
   assign w_push  = w_fin_ok && (!w_full || w_pop);
   assign w_drop  = w_fin_ok && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {r_fin_ch, r_fin_data};
   end

   assign rdata      = r_mem[r_rp];
   assign fifo_empty = w_empty;
   assign fifo_full  = w_full;
   assign fifo_level = r_level;
   assign fifo_above = (r_level > fifo_thr);
   assign ovf        = r_ovf;

   assign busy       = (r_state != S_IDLE) || r_fin;
   assign ch_sel_out = r_ch;
   assign sample_n   = (r_state != S_SAMPLE);
   assign dac_rst    = (r_state == S_RST);
   assign eoc        = r_eoc;
   assign result     = r_result;

endmodule

// File: tb/tb_adc_sar_seq_ovs.sv
// Directed bench for adc_sar_seq_ovs with a 4-deep FIFO and an ideal comparator model.
module tb_adc_sar_seq_ovs;
   localparam int RES      = 10;
   localparam int NCH      = 8;
   localparam int SEQ_LEN  = 8;
   localparam int FIFO_AW  = 2;
   localparam int CLKDIV_W = 8;
   localparam int CHW      = 3;

   logic                       clk = 1'b0;
   logic                       rst, en, cmp, soc, abort, rd, ovf_clr;
   logic [CLKDIV_W-1:0]        clkdiv;
   logic [3:0]                 swidth;
   logic [1:0]                 mode;
   logic [CHW-1:0]             ch_sel;
   logic [SEQ_LEN*(CHW+1)-1:0] seq_cfg;
   logic [2:0]                 osr;
   logic [CHW-1:0]             ch_sel_out;
   logic                       sample_n, dac_rst, busy, eoc;
   logic [RES-1:0]             result;
   logic [CHW+RES-1:0]         rdata;
   logic                       fifo_empty, fifo_full, fifo_above, ovf;
   logic [FIFO_AW:0]           fifo_level, fifo_thr;

   int n_chk = 0;
   int n_err = 0;
   int conv_cnt = 0;
   int conv_base = 0;
   logic           alt_en;
   logic [RES-1:0] base_vin, vin;
   logic [CHW+RES-1:0] d;
   int c, seen;

   adc_sar_seq_ovs #(.RES(RES), .NCH(NCH), .SEQ_LEN(SEQ_LEN), .FIFO_AW(FIFO_AW),
                     .CLKDIV_W(CLKDIV_W)) dut (
      .clk(clk), .rst(rst), .en(en), .clkdiv(clkdiv), .swidth(swidth), .cmp(cmp),
      .soc(soc), .mode(mode), .ch_sel(ch_sel), .seq_cfg(seq_cfg), .osr(osr),
      .abort(abort), .ch_sel_out(ch_sel_out), .sample_n(sample_n), .dac_rst(dac_rst),
      .busy(busy), .eoc(eoc), .result(result), .rd(rd), .rdata(rdata),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
      .fifo_thr(fifo_thr), .fifo_above(fifo_above), .ovf(ovf), .ovf_clr(ovf_clr));

   always #5 clk = ~clk;

   // Analog input: fixed, or alternating 100/103 per conversion.
   always @(posedge dac_rst) conv_cnt++;
   assign vin = alt_en ? ((((conv_cnt - conv_base) % 2) == 1) ? 10'd100 : 10'd103) : base_vin;
   assign cmp = (vin >= dut.r_sar);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_eoc(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!eoc && cyc < budget);
      if (!eoc) chk("eoc_timeout", eoc, 1);
   endtask

   task automatic wait_busy(input int budget);
      int k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!busy && k < budget);
      if (!busy) chk("busy_timeout", busy, 1);
   endtask

   task automatic pulse_soc();
      @(negedge clk) soc = 1'b1;
      @(negedge clk) soc = 1'b0;
   endtask

   task automatic pop(output logic [CHW+RES-1:0] v);
      @(negedge clk);
      v  = rdata;
      rd = 1'b1;
      @(negedge clk) rd = 1'b0;
   endtask

   task automatic idle_watch(input int n, output int eocs);
      eocs = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (eoc) eocs++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clkdiv = '0; swidth = 4'd1; soc = 1'b0; mode = 2'b00;
      ch_sel = 3'd3; seq_cfg = '0; osr = 3'd0; abort = 1'b0; rd = 1'b0;
      ovf_clr = 1'b0; fifo_thr = 3'd2; alt_en = 1'b0; base_vin = 10'h2A5;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_eoc", eoc, 0);
      chk("rst_dac_rst", dac_rst, 0);
      chk("rst_sample_n", sample_n, 1);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_above", fifo_above, 0);
      chk("rst_ch_out", ch_sel_out, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk) rst = 1'b0;

      // Single conversion, latency from the start tick.
      pulse_soc();
      wait_busy(10);
      chk("single_ch_out", ch_sel_out, 3);
      wait_eoc(40, c);
      chk("single_latency", c, 15);
      chk("single_result", result, 10'h2A5);
      chk("single_rdata", rdata, {3'd3, 10'h2A5});
      chk("single_level", fifo_level, 1);
      @(posedge clk); #1;
      chk("single_busy_end", busy, 0);
      chk("single_eoc_pulse", eoc, 0);
      pop(d);
      #1;
      chk("single_pop_empty", fifo_empty, 1);

      // Divided tick: ticks every third clk.
      clkdiv = 8'd2; ch_sel = 3'd6; base_vin = 10'h001;
      pulse_soc();
      wait_busy(10);
      wait_eoc(100, c);
      chk("div_latency", c, 43);
      chk("div_result", result, 1);
      chk("div_rdata", rdata, {3'd6, 10'h001});
      pop(d);
      clkdiv = 8'd0; base_vin = 10'h2A5;

      // Averaging of four conversions.
      osr = 3'd2; ch_sel = 3'd1; conv_base = conv_cnt; alt_en = 1'b1;
      pulse_soc();
      wait_busy(10);
      wait_eoc(200, c);
      chk("avg_result", result, 101);
      chk("avg_rdata", rdata, {3'd1, 10'd101});
      idle_watch(40, seen);
      chk("avg_one_eoc", seen, 0);
      chk("avg_level", fifo_level, 1);
      chk("avg_busy_end", busy, 0);
      pop(d);
      alt_en = 1'b0; osr = 3'd0;

      // Sequence-once: ch 5, 2, 7(end); soc while busy must not restart.
      seq_cfg = {20'd0, 4'hF, 4'h2, 4'h5}; mode = 2'b01;
      pulse_soc();
      wait_busy(10);
      for (int k = 0; k < 3; k++) begin
         wait_eoc(40, c);
         chk("seq_result", result, 10'h2A5);
         chk("seq_above", fifo_above, (k == 2) ? 1 : 0);
         if (k == 0) pulse_soc();
      end
      idle_watch(60, seen);
      chk("seq_no_extra", seen, 0);
      chk("seq_busy_end", busy, 0);
      chk("seq_level", fifo_level, 3);
      pop(d); chk("seq_ch0", d[CHW+RES-1:RES], 5);
      pop(d); chk("seq_ch1", d[CHW+RES-1:RES], 2);
      pop(d); chk("seq_ch2", d[CHW+RES-1:RES], 7);
      #1;
      chk("seq_empty", fifo_empty, 1);

      // Sequence-continuous: fill, push+pop while full, then drop.
      mode = 2'b10;
      pulse_soc();
      wait_busy(10);
      for (int k = 0; k < 4; k++) wait_eoc(40, c);
      chk("cont_full", fifo_full, 1);
      chk("cont_level4", fifo_level, 4);
      repeat (13) @(posedge clk);
      #1 rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
      chk("pp_eoc", eoc, 1);
      chk("pp_level", fifo_level, 4);
      chk("pp_ovf", ovf, 0);
      wait_eoc(40, c);
      chk("drop_ovf", ovf, 1);
      chk("drop_level", fifo_level, 4);
      @(negedge clk) abort = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle", busy, 0);
      @(negedge clk) abort = 1'b0;
      idle_watch(40, seen);
      chk("abort_no_eoc", seen, 0);
      chk("abort_fifo_kept", fifo_level, 4);
      @(negedge clk) ovf_clr = 1'b1;
      @(negedge clk) ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 0);
      pop(d); chk("cont_ch0", d[CHW+RES-1:RES], 2);
      pop(d); chk("cont_ch1", d[CHW+RES-1:RES], 7);
      pop(d); chk("cont_ch2", d[CHW+RES-1:RES], 5);
      pop(d); chk("cont_ch3", d[CHW+RES-1:RES], 2);
      #1;
      chk("drain_empty", fifo_empty, 1);
      pop(d);
      #1;
      chk("extra_pop_level", fifo_level, 0);
      chk("extra_pop_empty", fifo_empty, 1);

      // Abort mid-CONV in single mode.
      mode = 2'b00; ch_sel = 3'd4;
      pulse_soc();
      wait_busy(10);
      repeat (6) @(posedge clk);
      @(negedge clk) abort = 1'b1;
      @(posedge clk); #1;
      chk("abort_conv_busy", busy, 0);
      chk("abort_conv_sample_n", sample_n, 1);
      @(negedge clk) abort = 1'b0;
      idle_watch(40, seen);
      chk("abort_conv_no_eoc", seen, 0);
      chk("abort_conv_level", fifo_level, 0);

      // Reset mid-CONV.
      pulse_soc();
      wait_busy(10);
      repeat (6) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_conv_busy", busy, 0);
      chk("rst_conv_result", result, 0);
      @(negedge clk) rst = 1'b0;
      idle_watch(40, seen);
      chk("rst_conv_no_eoc", seen, 0);
      chk("rst_conv_level", fifo_level, 0);

      // en=0 freezes the FSM in SAMPLE.
      pulse_soc();
      wait_busy(10);
      @(posedge clk);
      @(posedge clk); #1;
      en = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("freeze_sample_n", sample_n, 0);
      chk("freeze_busy", busy, 1);
      en = 1'b1;
      wait_eoc(40, c);
      chk("freeze_resume", c, 13);
      chk("freeze_rdata", rdata, {3'd4, 10'h2A5});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
